// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: latches one word plus its framing config per handshake
// and shifts start, data (LSB first), optional parity and stop bits onto a registered tx line.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  txValid,
    output logic                  txReady,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic [DIV_WIDTH-1:0]  cfgDivisor,
    input  logic [4:0]            cfgOverSampling,
    input  logic [3:0]            cfgDataBits,
    input  logic                  cfgParityEnable,
    input  logic                  cfgParityType,
    input  logic                  cfgParityErrorInject,
    input  logic [1:0]            cfgStopBits,
    output logic                  tx,
    output logic                  busy,
    output logic                  txDone,
    output logic [2:0]            dbg_state
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state, state_n;
    logic [DIV_WIDTH-1:0]  tick_cnt, tick_cnt_n;
    logic [4:0]            sample_cnt, sample_cnt_n;
    logic [IW-1:0]         bit_idx, bit_idx_n;
    logic                  stop_cnt, stop_cnt_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic [3:0]            nbits_q, nbits_n;
    logic [4:0]            os_q, os_n;
    logic [DIV_WIDTH-1:0]  div_q, div_n;
    logic                  par_en_q, par_en_n;
    logic                  par_bit_q, par_bit_n;
    logic                  two_stop_q, two_stop_n;
    logic                  tx_n, done_n;

    logic [3:0]            nbits_s;
    logic [4:0]            os_s;
    logic [DIV_WIDTH-1:0]  div_s;
    logic                  par_s;
    logic                  tick_wrap, bit_end;

    // Handshake: a word transfers on a rising edge where txValid && txReady; txReady is
    // high only in IDLE, txValid may be held and the word/config are sampled only at that edge.
    assign txReady   = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Out-of-range config is clamped as it is latched, so the frame logic never sees it.
    always_comb begin
        nbits_s = cfgDataBits;
        if (cfgDataBits < 4'd5)
            nbits_s = 4'd5;
        else if (cfgDataBits > MAX_BITS)
            nbits_s = MAX_BITS;
        os_s  = (cfgOverSampling == 5'd13) ? 5'd13 : 5'd16;
        div_s = (cfgDivisor == '0) ? DIV_WIDTH'(1) : cfgDivisor;
        par_s = cfgParityType ^ cfgParityErrorInject;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < int'(nbits_s))
                par_s = par_s ^ txData[i];
        end
    end

    assign tick_wrap = (tick_cnt == div_q - DIV_WIDTH'(1));
    assign bit_end   = tick_wrap && (sample_cnt == os_q - 5'd1);

    always_comb begin
        state_n      = state;
        tick_cnt_n   = tick_cnt;
        sample_cnt_n = sample_cnt;
        bit_idx_n    = bit_idx;
        stop_cnt_n   = stop_cnt;
        data_n       = data_q;
        nbits_n      = nbits_q;
        os_n         = os_q;
        div_n        = div_q;
        par_en_n     = par_en_q;
        par_bit_n    = par_bit_q;
        two_stop_n   = two_stop_q;
        done_n       = 1'b0;
        tx_n         = 1'b1;

        if (state == S_IDLE) begin
            if (txValid) begin
                state_n      = S_START;
                tick_cnt_n   = '0;
                sample_cnt_n = '0;
                bit_idx_n    = '0;
                stop_cnt_n   = 1'b0;
                data_n       = txData;
                nbits_n      = nbits_s;
                os_n         = os_s;
                div_n        = div_s;
                par_en_n     = cfgParityEnable;
                par_bit_n    = par_s;
                two_stop_n   = (cfgStopBits == 2'd2);
            end
        end else begin
            if (tick_wrap) begin
                tick_cnt_n   = '0;
                sample_cnt_n = bit_end ? 5'd0 : sample_cnt + 5'd1;
            end else begin
                tick_cnt_n = tick_cnt + DIV_WIDTH'(1);
            end
            if (bit_end) begin
                case (state)
                    S_START: begin
                        state_n   = S_DATA;
                        bit_idx_n = '0;
                    end
                    S_DATA: begin
                        if (4'(bit_idx) == nbits_q - 4'd1)
                            state_n = par_en_q ? S_PARITY : S_STOP;
                        else
                            bit_idx_n = bit_idx + IW'(1);
                    end
                    S_PARITY: state_n = S_STOP;
                    S_STOP: begin
                        if (two_stop_q && !stop_cnt) begin
                            stop_cnt_n = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end

        // tx is registered from the next-state view so it changes together with the state.
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = data_n[bit_idx_n];
            S_PARITY: tx_n = par_bit_n;
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            sample_cnt <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            data_q     <= '0;
            nbits_q    <= '0;
            os_q       <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx         <= 1'b1;
            txDone     <= 1'b0;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_cnt_n;
            sample_cnt <= sample_cnt_n;
            bit_idx    <= bit_idx_n;
            stop_cnt   <= stop_cnt_n;
            data_q     <= data_n;
            nbits_q    <= nbits_n;
            os_q       <= os_n;
            div_q      <= div_n;
            par_en_q   <= par_en_n;
            par_bit_q  <= par_bit_n;
            two_stop_q <= two_stop_n;
            tx         <= tx_n;
            txDone     <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: compares tx every clock against a per-cycle
// expected queue built from the frame definition, plus handshake, done and reset behaviour.
module tb_uart_tx_serializer;

    logic        clk;
    logic        rst_n;
    logic        txValid;
    logic        txReady;
    logic [7:0]  txData;
    logic [15:0] cfgDivisor;
    logic [4:0]  cfgOverSampling;
    logic [3:0]  cfgDataBits;
    logic        cfgParityEnable;
    logic        cfgParityType;
    logic        cfgParityErrorInject;
    logic [1:0]  cfgStopBits;
    logic        tx;
    logic        busy;
    logic        txDone;
    logic [2:0]  dbg_state;

    logic [0:0]  exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    uart_tx_serializer #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .txValid              (txValid),
        .txReady              (txReady),
        .txData               (txData),
        .cfgDivisor           (cfgDivisor),
        .cfgOverSampling      (cfgOverSampling),
        .cfgDataBits          (cfgDataBits),
        .cfgParityEnable      (cfgParityEnable),
        .cfgParityType        (cfgParityType),
        .cfgParityErrorInject (cfgParityErrorInject),
        .cfgStopBits          (cfgStopBits),
        .tx                   (tx),
        .busy                 (busy),
        .txDone               (txDone),
        .dbg_state            (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives a word/config with txValid high and queues the tx level expected on every
    // clock of the resulting frame, derived from the frame format with clamped config.
    task automatic start_frame(input logic [7:0] d, input logic [15:0] dv, input logic [4:0] os,
                               input logic [3:0] nb, input logic pe, input logic pt,
                               input logic pi, input logic [1:0] sb);
        int n;
        int o;
        int v;
        int stops;
        logic par;
        logic [0:0] bits[$];
        txData               = d;
        cfgDivisor           = dv;
        cfgOverSampling      = os;
        cfgDataBits          = nb;
        cfgParityEnable      = pe;
        cfgParityType        = pt;
        cfgParityErrorInject = pi;
        cfgStopBits          = sb;
        txValid              = 1'b1;
        n     = (nb < 4'd5) ? 5 : ((nb > 4'd8) ? 8 : int'(nb));
        o     = (os == 5'd13) ? 13 : 16;
        v     = (dv == 16'd0) ? 1 : int'(dv);
        stops = (sb == 2'd2) ? 2 : 1;
        par   = pt ^ pi;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[i]);
            par = par ^ d[i];
        end
        if (pe) bits.push_back(par);
        for (int i = 0; i < stops; i++) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int j = 0; j < o * v; j++) exp_q.push_back(bits[k]);
        end
    endtask

    // Checks every frame clock; on the first one either drops txValid or swaps in the next word.
    task automatic check_frame(input string name, input bit drop, input logic [7:0] next_data);
        int k;
        logic [0:0] e;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            if (k == 0) begin
                if (drop) txValid = 1'b0;
                else      txData  = next_data;
                check($sformatf("%s busy_first", name), busy, 1);
                check($sformatf("%s ready_first", name), txReady, 0);
            end
            check($sformatf("%s tx[%0d]", name, k), tx, e);
            check($sformatf("%s no_done[%0d]", name, k), txDone, 0);
            k++;
        end
    endtask

    task automatic check_end(input string name);
        @(negedge clk);
        check($sformatf("%s end_tx", name), tx, 1);
        check($sformatf("%s end_done", name), txDone, 1);
        check($sformatf("%s end_ready", name), txReady, 1);
        check($sformatf("%s end_busy", name), busy, 0);
    endtask

    task automatic check_quiet(input string name);
        @(negedge clk);
        check($sformatf("%s done_cleared", name), txDone, 0);
        check($sformatf("%s idle_tx", name), tx, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        txValid = 1'b0;
        txData = '0;
        cfgDivisor = '0;
        cfgOverSampling = '0;
        cfgDataBits = '0;
        cfgParityEnable = 1'b0;
        cfgParityType = 1'b0;
        cfgParityErrorInject = 1'b0;
        cfgStopBits = '0;
        repeat (2) @(negedge clk);
        check("rst tx", tx, 1);
        check("rst busy", busy, 0);
        check("rst done", txDone, 0);
        check("rst ready", txReady, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // 8-bit even parity, 0xA5: 11 bits x 16 clk
        start_frame(8'hA5, 16'd1, 5'd16, 4'd8, 1'b1, 1'b0, 1'b0, 2'd1);
        check_frame("even8", 1'b1, 8'h00);
        check_end("even8");
        check_quiet("even8");

        // 5-bit odd parity, 2 stop, 0xFF: 9 bits x 26 clk
        start_frame(8'hFF, 16'd2, 5'd13, 4'd5, 1'b1, 1'b1, 1'b0, 2'd2);
        check_frame("odd5", 1'b1, 8'h00);
        check_end("odd5");
        check_quiet("odd5");

        // parity injection flips the parity bit of 0x03 to 1
        start_frame(8'h03, 16'd1, 5'd16, 4'd8, 1'b1, 1'b0, 1'b1, 2'd1);
        check_frame("inject", 1'b1, 8'h00);
        check_end("inject");
        check_quiet("inject");

        // back-to-back: txValid held, second word accepted in the txDone cycle
        start_frame(8'h55, 16'd1, 5'd13, 4'd8, 1'b0, 1'b0, 1'b0, 2'd1);
        check_frame("b2b0", 1'b0, 8'h0F);
        check_end("b2b0");
        start_frame(8'h0F, 16'd1, 5'd13, 4'd8, 1'b0, 1'b0, 1'b0, 2'd1);
        check_frame("b2b1", 1'b1, 8'h00);
        check_end("b2b1");
        check_quiet("b2b1");

        // reset during data bit 3 of 0x3C
        start_frame(8'h3C, 16'd1, 5'd16, 4'd8, 1'b0, 1'b0, 1'b0, 2'd1);
        @(negedge clk);
        txValid = 1'b0;
        repeat (69) @(negedge clk);
        check("midrst busy_before", busy, 1);
        check("midrst tx_bit3", tx, 1);
        check("midrst state_data", dbg_state, 3'd2);
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        check("midrst tx", tx, 1);
        check("midrst busy", busy, 0);
        check("midrst done", txDone, 0);
        check("midrst ready", txReady, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midrst hold_done[%0d]", i), txDone, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst done", txDone, 0);
        start_frame(8'h3C, 16'd1, 5'd16, 4'd8, 1'b0, 1'b0, 1'b0, 2'd1);
        check_frame("postrst", 1'b1, 8'h00);
        check_end("postrst");
        check_quiet("postrst");

        // illegal config clamps to 5 bits, 1 stop, OS=16, DIV=1: 112 clk
        start_frame(8'h1F, 16'd0, 5'd7, 4'd3, 1'b0, 1'b0, 1'b0, 2'd0);
        check_frame("illegal", 1'b1, 8'h00);
        check_end("illegal");
        check_quiet("illegal");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
